// File: rtl/alu_seg_pkg.sv
// Shared definitions for the ALU / seven-segment unit: opcodes, FSM states, hex glyph table.
package alu_seg_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_ACC = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Segment patterns, MSB = segment a ... LSB = segment g; entry index = hex digit.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-digit to active-high seven-segment decoder (seg_o[0]=a .. seg_o[6]=g).
module seg7_hex_decoder
  import alu_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [0:6] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/alu_seg_unit.sv
// W-bit registered ALU with accumulator, shift-add multiplier and hex display output.
module alu_seg_unit
  import alu_seg_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] result,
  output logic         flag,
  output logic         out_valid,
  output logic [0:6]   seg
);

  localparam int CNT_W = $clog2(W);

  state_e               state_q;
  logic [W-1:0]         acc_q, acc_d;
  logic [W-1:0]         result_q, res_d;
  logic                 flag_q, flag_d;
  logic                 vld_q;
  logic [2*W-1:0]       mcand_q;
  logic [W-1:0]         mplier_q;
  logic [2*W-1:0]       prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [W:0]           add_w, sub_w, acc_w;
  logic                 mul_last;
  logic [3:0]           nib;

  assign in_ready = (state_q == ST_IDLE);
  assign mul_last = (cnt_q == CNT_W'(W - 1));

  // Single-cycle op results and the next shift-add partial product.
  always_comb begin
    add_w  = {1'b0, in1} + {1'b0, in2};
    sub_w  = {1'b0, in1} - {1'b0, in2};
    acc_w  = {1'b0, acc_q} + {1'b0, in1};
    acc_d  = acc_q;
    res_d  = '0;
    flag_d = 1'b0;
    case (op)
      OP_ADD: begin res_d = add_w[W-1:0]; flag_d = add_w[W]; end
      OP_SUB: begin res_d = sub_w[W-1:0]; flag_d = sub_w[W]; end
      OP_AND: res_d = in1 & in2;
      OP_OR:  res_d = in1 | in2;
      OP_XOR: res_d = in1 ^ in2;
      OP_ACC: begin acc_d = acc_w[W-1:0]; res_d = acc_w[W-1:0]; flag_d = acc_w[W]; end
      OP_CLR: acc_d = '0;
      default: ;
    endcase
    prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  end

  // Control FSM, accumulator and output registers; multiplier datapath is never reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      vld_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand_q  <= {{W{1'b0}}, in1};
              mplier_q <= in2;
              prod_q   <= '0;
              cnt_q    <= '0;
              state_q  <= ST_MUL;
            end else begin
              result_q <= res_d;
              flag_q   <= flag_d;
              acc_q    <= acc_d;
              vld_q    <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (mul_last) begin
            result_q <= prod_d[W-1:0];
            flag_q   <= |prod_d[2*W-1:W];
            vld_q    <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  if (W >= 4) begin : g_nib
    assign nib = result_q[3:0];
  end else begin : g_nib_ext
    assign nib = {{(4 - W){1'b0}}, result_q};
  end

  seg7_hex_decoder u_dec (
    .hex_i (nib),
    .seg_o (seg)
  );

  assign result    = result_q;
  assign flag      = flag_q;
  assign out_valid = vld_q;

endmodule
